bk_mem_arbiter: RTL and testbench

Single-port memory arbiter that shares the system RAM between three requesters: the video refresh fetch, the CPU bus, and the disk/DMA copy engine. It sits between `memory`'s address decode and the physical RAM port, sequencing one access at a time with fixed-latency handshakes. Video always wins, so refresh deadlines are met. CPU and DMA share the remaining slots.

---
 rtl/bk_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_bk_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_mem_arbiter.sv
// rtl/bk_mem_arbiter.sv - single-port RAM arbiter for video, CPU and DMA requesters
//
// Sequences one RAM access at a time through IDLE -> ISSUE -> WAIT -> DONE.
// Video has absolute priority; CPU beats DMA unless MEMARB_RR_EN is defined,
// in which case CPU and DMA alternate when both are pending.
//
// Ports:
//   clk_sys, reset_n                       clock, synchronous active-low reset
//   vid_req/addr -> vid_dout/valid         video read port
//   cpu_req/we/be/addr/din -> dout/ack     CPU port
//   dma_req/we/addr/din -> dout/ack        DMA port (full-word writes)
//   ram_addr/din/be/rd/we <- ram_dout      physical RAM port
//   grant (0 none, 1 video, 2 CPU, 3 DMA), busy
module bk_mem_arbiter #(
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int RAM_LAT = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_din,
    output logic [DW-1:0] dma_dout,
    output logic          dma_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [1:0]    ram_be,
    output logic          ram_rd,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(RAM_LAT - 1);

    state_t     state, state_nxt;
    logic [2:0] wait_cnt;
    logic [1:0] pick;
    logic       we_q;

`ifdef MEMARB_RR_EN
    // Set when DMA should win the next CPU/DMA tie.
    logic       rr_dma_next;
`endif

    // Winner selection, only meaningful while in IDLE.
    always_comb begin
        pick = 2'd0;
        if (vid_req) begin
            pick = 2'd1;
        end else if (cpu_req && dma_req) begin
`ifdef MEMARB_RR_EN
            pick = rr_dma_next ? 2'd3 : 2'd2;
`else
            pick = 2'd2;
`endif
        end else if (cpu_req) begin
            pick = 2'd2;
        end else if (dma_req) begin
            pick = 2'd3;
        end
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick != 2'd0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (RAM_LAT == 1) ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt == 3'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ram_rd = (state == S_ISSUE) && !we_q;
        ram_we = (state == S_ISSUE) && we_q;
        busy   = (state != S_IDLE);
    end

    // Datapath: request latch, wait counter, completion registers.
    // Ack and dout are loaded on the edge entering DONE so that both are
    // visible together in the DONE cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            grant     <= 2'd0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_be    <= 2'b00;
            we_q      <= 1'b0;
            wait_cnt  <= 3'd0;
            vid_dout  <= '0;
            cpu_dout  <= '0;
            dma_dout  <= '0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
`ifdef MEMARB_RR_EN
            rr_dma_next <= 1'b0;
`endif
        end else begin
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            case (state)
                S_IDLE: begin
                    grant <= pick;
                    case (pick)
                        2'd1: begin
                            ram_addr <= vid_addr;
                            ram_din  <= '0;
                            ram_be   <= 2'b11;
                            we_q     <= 1'b0;
                        end
                        2'd2: begin
                            ram_addr <= cpu_addr;
                            ram_din  <= cpu_din;
                            ram_be   <= cpu_be;
                            we_q     <= cpu_we;
`ifdef MEMARB_RR_EN
                            rr_dma_next <= 1'b1;
`endif
                        end
                        2'd3: begin
                            ram_addr <= dma_addr;
                            ram_din  <= dma_din;
                            ram_be   <= 2'b11;
                            we_q     <= dma_we;
`ifdef MEMARB_RR_EN
                            rr_dma_next <= 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: wait_cnt <= WAIT_LOAD;
                S_WAIT:  wait_cnt <= wait_cnt - 3'd1;
                S_DONE:  grant <= 2'd0;
                default: ;
            endcase

            if (state != S_DONE && state_nxt == S_DONE) begin
                case (grant)
                    2'd1: begin
                        vid_valid <= 1'b1;
                        vid_dout  <= ram_dout;
                    end
                    2'd2: begin
                        cpu_ack <= 1'b1;
                        if (!we_q) cpu_dout <= ram_dout;
                    end
                    2'd3: begin
                        dma_ack <= 1'b1;
                        if (!we_q) dma_dout <= ram_dout;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// tb/tb_bk_mem_arbiter.sv - directed self-checking bench for bk_mem_arbiter
module tb_bk_mem_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_dout;
    logic          vid_valid;
    logic          cpu_req, cpu_we;
    logic [1:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          cpu_ack;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_din, dma_dout;
    logic          dma_ack;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [1:0]    ram_be;
    logic          ram_rd, ram_we;
    logic [DW-1:0] ram_dout;
    logic [1:0]    grant;
    logic          busy;

    // Second instance built with RAM_LAT = 1; only its CPU port is exercised.
    logic          c1_req;
    logic [DW-1:0] v1_dout, c1_dout, d1_dout;
    logic          v1_valid, c1_ack, d1_ack;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_din;
    logic [1:0]    r1_be, grant1;
    logic          r1_rd, r1_we, busy1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    bk_mem_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(2)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ack(dma_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_be(ram_be), .ram_rd(ram_rd),
        .ram_we(ram_we), .ram_dout(ram_dout), .grant(grant), .busy(busy)
    );

    bk_mem_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(1)) u_dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vid_req(1'b0), .vid_addr('0), .vid_dout(v1_dout), .vid_valid(v1_valid),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_be(2'b11), .cpu_addr(22'h000ABC),
        .cpu_din('0), .cpu_dout(c1_dout), .cpu_ack(c1_ack),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr('0), .dma_din('0),
        .dma_dout(d1_dout), .dma_ack(d1_ack),
        .ram_addr(r1_addr), .ram_din(r1_din), .ram_be(r1_be), .ram_rd(r1_rd),
        .ram_we(r1_we), .ram_dout(ram_dout), .grant(grant1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int       vid_t, cpu_t, dma_t, multi, n, lat;
    logic [1:0] g [8];
    logic     found;
    logic [1:0] exp_g;

    initial begin
        reset_n = 1'b0;
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_be = 2'b11; cpu_addr = '0; cpu_din = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = '0;
        ram_dout = '0; c1_req = 0;
        tick(); tick(); tick();

        // Reset state
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", {30'd0, ram_rd, ram_we}, 0);
        check("rst_acks", {29'd0, vid_valid, cpu_ack, dma_ack}, 0);
        reset_n = 1'b1;
        tick();

        // Single CPU read
        ram_dout = 16'h1234;
        cpu_addr = 22'h000100; cpu_we = 0; cpu_be = 2'b11; cpu_req = 1;
        tick();
        check("rd_strobe", 32'(ram_rd), 1);
        check("rd_addr", 32'(ram_addr), 32'h100);
        check("rd_grant_c1", 32'(grant), 2);
        check("rd_noack_c1", 32'(cpu_ack), 0);
        tick();
        check("rd_strobe_off", 32'(ram_rd), 0);
        check("rd_grant_c2", 32'(grant), 2);
        check("rd_noack_c2", 32'(cpu_ack), 0);
        tick();
        check("rd_ack", 32'(cpu_ack), 1);
        check("rd_dout", 32'(cpu_dout), 32'h1234);
        check("rd_grant_c3", 32'(grant), 2);
        cpu_req = 0;
        tick();
        check("rd_ack_off", 32'(cpu_ack), 0);
        check("rd_idle_grant", 32'(grant), 0);
        check("rd_idle_busy", 32'(busy), 0);

        // CPU byte write
        ram_dout = 16'h9999;
        cpu_addr = 22'h000200; cpu_we = 1; cpu_be = 2'b10; cpu_din = 16'hAB00; cpu_req = 1;
        tick();
        check("wr_we", 32'(ram_we), 1);
        check("wr_rd", 32'(ram_rd), 0);
        check("wr_be", 32'(ram_be), 2);
        check("wr_din", 32'(ram_din), 32'hAB00);
        tick();
        check("wr_we_off", 32'(ram_we), 0);
        tick();
        check("wr_ack", 32'(cpu_ack), 1);
        check("wr_dout_keep", 32'(cpu_dout), 32'h1234);
        cpu_req = 0; cpu_we = 0; cpu_be = 2'b11;
        tick();
        check("wr_ack_once", 32'(cpu_ack), 0);

        // Simultaneous video, CPU, DMA
        ram_dout = 16'h5555;
        vid_addr = 22'h1; cpu_addr = 22'h2; dma_addr = 22'h3;
        vid_req = 1; cpu_req = 1; dma_req = 1;
        vid_t = 0; cpu_t = 0; dma_t = 0; multi = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) check("tri_grant_vid", 32'(grant), 1);
            if (i == 5) check("tri_grant_cpu", 32'(grant), 2);
            if (i == 9) check("tri_grant_dma", 32'(grant), 3);
            if (32'(vid_valid) + 32'(cpu_ack) + 32'(dma_ack) > 1) multi++;
            if (vid_valid) begin vid_t = i; vid_req = 0; end
            if (cpu_ack)   begin cpu_t = i; cpu_req = 0; end
            if (dma_ack)   begin dma_t = i; dma_req = 0; end
        end
        check("tri_vid_t", vid_t, 3);
        check("tri_cpu_t", cpu_t, 7);
        check("tri_dma_t", dma_t, 11);
        check("tri_multi", multi, 0);
        check("tri_vid_dout", 32'(vid_dout), 32'h5555);
        check("tri_dma_dout", 32'(dma_dout), 32'h5555);

        // Continuous CPU + DMA
        ram_dout = 16'h7777;
        cpu_req = 1; dma_req = 1; n = 0;
        for (int i = 0; i < 80 && n < 8; i++) begin
            tick();
            if (ram_rd) begin g[n] = grant; n++; end
        end
        check("cont_count", n, 8);
        for (int k = 0; k < 8; k++) begin
`ifdef MEMARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'd2 : 2'd3;
`else
            exp_g = 2'd2;
`endif
            check($sformatf("cont_grant_%0d", k), 32'(g[k]), 32'(exp_g));
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (cpu_ack || dma_ack) begin cpu_req = 0; found = 1; end
        end
        check("cont_ack_seen", 32'(found), 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ram_rd) begin check("cont_dma_after", 32'(grant), 3); found = 1; end
        end
        check("cont_dma_strobe", 32'(found), 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (dma_ack) begin dma_req = 0; found = 1; end
        end
        check("cont_dma_ack", 32'(found), 1);
        tick();

        // Reset during WAIT of a DMA read
        dma_addr = 22'h40; dma_req = 1;
        tick();
        check("rw_issue_grant", 32'(grant), 3);
        tick();
        check("rw_wait_busy", 32'(busy), 1);
        reset_n = 0; dma_req = 0;
        tick();
        check("rw_busy", 32'(busy), 0);
        check("rw_grant", 32'(grant), 0);
        check("rw_noack", 32'(dma_ack), 0);
        check("rw_douts", {vid_dout, cpu_dout} | 32'(dma_dout), 0);
        reset_n = 1;
        tick();
        check("rw_noack_post", 32'(dma_ack), 0);
        ram_dout = 16'h0F0F;
        cpu_addr = 22'h50; cpu_req = 1; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cpu_ack) begin lat = i; break; end
        end
        cpu_req = 0;
        check("rw_cpu_lat", lat, 3);
        check("rw_cpu_dout", 32'(cpu_dout), 32'h0F0F);
        tick();

        // RAM_LAT = 1 instance
        ram_dout = 16'hBEEF;
        c1_req = 1;
        tick();
        check("l1_strobe", 32'(r1_rd), 1);
        check("l1_grant", 32'(grant1), 2);
        check("l1_noack", 32'(c1_ack), 0);
        tick();
        check("l1_ack", 32'(c1_ack), 1);
        check("l1_dout", 32'(c1_dout), 32'hBEEF);
        c1_req = 0;
        tick();
        check("l1_idle", 32'(busy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
